// File: rtl/counter_sched_pkg.sv
// counter_sched shared definitions
// FSM encodings and default sizing for the shared-counter scheduler
package counter_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_e;

  localparam int SCHED_NUM_REQ = 4;
  localparam int SCHED_WIDTH   = 3;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// counter_sched round-robin pick
// First set request at or after ptr, searching upward with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // scan from farthest to nearest so the nearest hit lands last
  always_comb begin
    pick = '0;
    idx  = '0;
    j    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        pick = {{(N-1){1'b0}}, 1'b1} << j;
        idx  = j;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched top
// Grants one shared counter to requesters in round-robin order
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = SCHED_NUM_REQ,
  parameter int WIDTH   = SCHED_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] dur,
  input  logic                     pause,
  input  logic [WIDTH-1:0]         count,
  output logic                     cnt_enable,
  output logic                     cnt_reset,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_e state, state_n;

  logic [IW-1:0]      owner;
  logic [IW-1:0]      owner_inc;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] own_oh;
  logic [WIDTH-1:0]   dur_lat;
  logic               pick_any;
  logic               at_end;
  logic               abort;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign pick_any = |pick;
  assign at_end   = (count == dur_lat);
  // completion outranks a dropped request
  assign abort    = (state == SCHED_RUN)
                  && !at_end && !req[owner];
  assign own_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1}
                  << owner;
  assign owner_inc =
    (owner == IW'(NUM_REQ - 1)) ? '0
                                : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) state <= SCHED_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner   <= '0;
      dur_lat <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == SCHED_IDLE && pick_any) begin
        owner   <= pick_idx;
        dur_lat <= dur[pick_idx*WIDTH +: WIDTH];
      end
      if (state == SCHED_DONE || abort)
        rr_ptr <= owner_inc;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      SCHED_IDLE:
        if (pick_any) state_n = SCHED_RUN;
      SCHED_RUN:
        if (at_end)     state_n = SCHED_DONE;
        else if (abort) state_n = SCHED_IDLE;
      SCHED_DONE:
        state_n = SCHED_IDLE;
      default:
        state_n = SCHED_IDLE;
    endcase
  end

  always_comb begin
    cnt_enable = 1'b0;
    cnt_reset  = 1'b0;
    grant      = '0;
    done       = '0;
    busy       = 1'b0;
    case (state)
      SCHED_IDLE: cnt_reset = 1'b1;
      SCHED_RUN: begin
        grant      = own_oh;
        busy       = 1'b1;
        cnt_enable = !pause && !at_end;
      end
      SCHED_DONE: begin
        grant = own_oh;
        done  = own_oh;
        busy  = 1'b1;
      end
      default: cnt_reset = 1'b1;
    endcase
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares a single `counter` instance among NUM_REQ requesters. Each requester asks for an interval of D enabled counter cycles. The block grants the counter to one requester at a time, drives the counter's `enable`/`reset`, watches `count` until it reaches D, then pulses that requester's `done`. It sits between requesting control logic and the shared counter datapath.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- WIDTH, 3: counter width; must match the controlled counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- req  in  NUM_REQ  per-requester request level; held until done or abort
- dur  in  NUM_REQ*WIDTH  packed durations; requester i uses bits [i*WIDTH +: WIDTH]
- pause  in  1  freezes the running interval (counter enable low)
- count  in  WIDTH  current value of the shared counter
- cnt_enable  out  1  to counter `enable`
- cnt_reset  out  1  to counter `reset` (active-high, synchronous clear)
- grant  out  NUM_REQ  one-hot owner of the counter, zero when idle
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- busy  out  1  high in RUN and DONE

## Operation
- Counter contract: clears to 0 on a clk edge with `reset` high; increments on a clk edge with `enable` high; wraps at 2^WIDTH.
- FSM states are IDLE, RUN and DONE. Outputs are Moore-decoded from registered state plus `owner`/`dur_lat`, except `cnt_enable`.
- IDLE:
  - cnt_reset=1, cnt_enable=0, grant=0, busy=0.
  - If any req bit is set, pick the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Latch `owner` and `dur_lat`, then go to RUN.
- RUN:
  - grant=onehot(owner), busy=1, cnt_reset=0.
  - cnt_enable = !pause && (count != dur_lat), combinational.
  - If count == dur_lat, go to DONE.
  - Else if req[owner] is 0 (abort), go to IDLE with no done pulse and rr_ptr = owner+1.
- DONE:
  - done[owner]=1 for one cycle, grant held, cnt_enable=0, cnt_reset=0 (count holds D).
  - Next state is IDLE; rr_ptr = owner+1 mod NUM_REQ.
- Reset low on any edge: state=IDLE, rr_ptr=0, owner=0, dur_lat=0.
- Reset output values: cnt_reset=1, cnt_enable=0, grant=0, done=0, busy=0.
- A reset mid-RUN discards the interval and no done is issued.
- dur=0: RUN lasts one cycle (count already 0) and cnt_enable never rises.
- dur=2^WIDTH-1: the counter stops at max and never wraps.
- pause only affects RUN. Completion is checked on count, so pause during the final compare cycle does not delay DONE.
- Requests changing or dur changing while not owner are ignored until arbitration. dur changes of the owner after latch are ignored.
- Abort and completion in the same cycle: completion wins.

## Timing
- Edge E0 is an IDLE edge with req[i]=1 and i selected. After E0: RUN, grant[i]=1, count=0.
- Unpaused, RUN lasts D+1 cycles with cnt_enable high for the first D.
- DONE occupies the cycle after edge E0+D+1, so done[i] is high between E0+D+1 and E0+D+2.
- Each paused cycle adds one cycle.
- Back-to-back grants need at least one IDLE cycle, which re-clears the counter.
- Worst-case wait for requester i is (NUM_REQ-1) × (2^WIDTH+2) cycles, with no pause and no aborts.

## Structure
- Shared header (alongside params.vh) holds state encodings `SCHED_IDLE/RUN/DONE` (2-bit) and the default NUM_REQ/WIDTH.
- Sub-module `rr_arbiter`: combinational, takes req and rr_ptr, returns the one-hot pick and its index.
- `counter_sched` holds the FSM, owner/dur_lat/rr_ptr registers and output decode.
- The `counter` instance lives one level up, wired to cnt_enable/cnt_reset/count.

## Test plan
- Reset low 2 cycles, then high with req=0 -> cnt_reset=1, grant=0, busy=0, done=0, count stays 0.
- req=0010, dur[1]=5 at edge E0 -> grant=0010 after E0, cnt_enable high 5 cycles, count 0..5, done=0010 for exactly one cycle after E0+6, grant=0 after E0+7.
- req=1111, all dur=2 held -> grants in order 0001, 0010, 0100, 1000, 0001; each done separated by 5 cycles (RUN 3 + DONE 1 + IDLE 1).
- req=0001, dur=4, pause high 3 cycles mid-RUN -> count freezes at the paused value, done delayed by exactly 3 cycles, final count=4.
- req[2] dropped while count=2 of dur=6 -> no done, grant=0 next cycle, next grant search starts at index 3; dur=0 request -> done two cycles after grant edge, cnt_enable never high.
- reset low during RUN at count=3 -> next edge: grant=0, busy=0, cnt_reset=1, count cleared, rr_ptr=0 (req=1111 then grants 0001 first).
